fsb16_target: RTL and testbench
===============================

// Module: fsb16_target
// PURPOSE
//  FSB16 target (responder) end of the 16-bit multiplexed front-side bus driven by the AHB-side FSB16 bridge.
//  Decodes the two-frame address phase, runs one local-bus read or write per FSB transaction, and returns
//  data/rdy_n/error_n to the initiator. Sits in peripheral subsystems hung off the FSB16 link.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  window base; hit when (addr & ADDR_MASK) == BASE_ADDR
//  ADDR_MASK   32'hFFFF_0000  window decode mask
//  TIMEOUT     16             max cycles from lb_req rise to lb_ack before an error response (>=2)
//  IRQ_W       4              number of interrupt sources (used only with FSB16_TARGET_IRQ_EN)
// PORTS
//  clk        in   1   bus clock (FSB16 clk); all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  aen        in   1   address-frame enable from initiator
//  size       in   1   0 = 8-bit access, 1 = 16-bit
//  wr_n       in   1   sampled in address frames: 1 = write, 0 = read
//  AD_in      in   16  multiplexed address/data from initiator
//  AD_out     out  16  read data to initiator
//  ad_oe      out  1   pad drive enable for AD_out
//  rdy_n      out  1   active-low transfer complete
//  error_n    out  1   active-low transfer error
//  irq_n      out  1   active-low interrupt
//  lb_req     out  1   local bus request, held until lb_ack or lb_err
//  lb_we      out  1   local write
//  lb_addr    out  32  local address
//  lb_be      out  2   byte enables
//  lb_wdata   out  16  write data
//  lb_rdata   in   16  read data, valid with lb_ack
//  lb_ack     in   1   local completion
//  lb_err     in   1   local error completion
//  irq_src    in   IRQ_W  level interrupt sources
//  irq_mask   in   IRQ_W  1 = source enabled
// BEHAVIOUR
//  Reset: state=IDLE, rdy_n=1, error_n=1, irq_n=1, ad_oe=0, AD_out=0, lb_req=0, lb_we=0. A reset asserted
//   mid-transfer aborts the transfer immediately; no rdy_n/error_n is issued.
//  FSM: IDLE -> A1 -> (W_DATA | R_TA) -> LB_WAIT -> RESP -> IDLE.
//   IDLE: when aen=1, latch addr[15:0]=AD_in, is_wr=wr_n, sz=size -> A1.
//   A1: when aen=1, latch addr[31:16]=AD_in. If aen=0, this is a protocol error: drop the transfer -> IDLE with no response.
//       Decode miss -> RESP with error. Hit+write -> W_DATA. Hit+read -> R_TA, with lb_req raised on that same edge.
//   W_DATA: one cycle; latch lb_wdata=AD_in; raise lb_req, lb_we=1 -> LB_WAIT.
//   R_TA: turnaround (initiator nop frame); ad_oe stays 0 -> LB_WAIT.
//   LB_WAIT: on lb_err -> error; else on lb_ack -> ok (read: capture lb_rdata); lb_req drops on the same edge.
//       If lb_err and lb_ack assert together, lb_err wins. Timeout counter reaching TIMEOUT -> error;
//       if lb_ack arrives on that same cycle, lb_ack wins.
//   RESP: exactly one cycle, then IDLE.
//       ok: rdy_n=0; read responses drive AD_out=data with ad_oe=1.
//       error: error_n=0, AD_out=0, ad_oe=0.
//  Read latency: rdy_n no earlier than the 4th cycle after the first address frame; ad_oe never asserts before R_TA completes.
//  lb_be: sz=1 -> 2'b11; sz=0 -> addr[0] ? 2'b10 : 2'b01. Read returns the full 16-bit word; the byte lane is at the initiator's discretion.
//  aen while not IDLE/A1 is ignored. Back-to-back: a new aen in the cycle after RESP is accepted.
// CONFIGURATION
//  FSB16_TARGET_IRQ_EN defined: irq_n = ~|(irq_src & irq_mask), registered (1-cycle latency), reset 1.
//  Not defined: irq_n tied 1; irq_src/irq_mask unused.
// STRUCTURE
//  fsb16_pkg: state encodings, FSB_WRITE/FSB_READ wr_n values, SIZE_8/SIZE_16 constants.
//  Sub-module fsb16_tgt_timer: TIMEOUT counter with clear on lb_req rise and expire output.
// TESTING
//  1. Write: addr frames 16'h0010, 16'h0000, wr_n=1, size=1, data 16'hBEEF; lb_ack after 2 cycles
//     -> lb_addr=32'h10, lb_be=11, lb_wdata=BEEF, one-cycle rdy_n=0.
//  2. Read of 32'h0000_0022 with size=0, lb_rdata=16'h1234, lb_ack immediate
//     -> lb_be=01, rdy_n=0 with AD_out=1234, ad_oe=1, on cycle 4 after the first aen.
//  3. Read of 32'h0001_0000 (decode miss) -> no lb_req; error_n=0 for one cycle.
//  4. lb_ack never asserts with TIMEOUT=16 -> error_n=0 sixteen cycles after lb_req rises; lb_req drops.
//  5. lb_ack and lb_err assert together -> error_n=0, rdy_n stays 1. Separately: rst during LB_WAIT
//     -> all outputs take their reset values on the next edge.
//  6. IRQ_EN: irq_src=4'b0100, mask=4'b0100 -> irq_n=0 one cycle later; mask=0 -> irq_n=1.

Source files
------------

// File: rtl/fsb16_pkg.sv
// fsb16_pkg
//   Shared constants for the FSB16 target: FSM state encodings, wr_n/size
//   frame encodings, the latched address-phase record and the byte-enable
//   helper used to drive the local bus.
package fsb16_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_A1      = 3'd1;
    localparam logic [2:0] ST_W_DATA  = 3'd2;
    localparam logic [2:0] ST_R_TA    = 3'd3;
    localparam logic [2:0] ST_LB_WAIT = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    localparam logic FSB_WRITE = 1'b1;
    localparam logic FSB_READ  = 1'b0;

    localparam logic SIZE_8  = 1'b0;
    localparam logic SIZE_16 = 1'b1;

    // Address-phase information captured across the two address frames.
    typedef struct packed {
        logic [31:0] addr;
        logic        is_wr;
        logic        sz;
    } xfer_t;

    // 16-bit accesses enable both lanes; byte accesses pick the lane by addr[0].
    function automatic logic [1:0] byte_en(input logic sz, input logic a0);
        if (sz == SIZE_16) begin
            return 2'b11;
        end
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fsb16_target_if.sv
// fsb16_target_if
//   FSB16 bus signals between the initiator (bridge) and a target.
//   master : drives aen, size, wr_n, AD_in; observes AD_out, ad_oe, rdy_n,
//            error_n, irq_n
//   slave  : the mirror view, used by fsb16_target
interface fsb16_target_if;
    logic        aen;
    logic        size;
    logic        wr_n;
    logic [15:0] AD_in;
    logic [15:0] AD_out;
    logic        ad_oe;
    logic        rdy_n;
    logic        error_n;
    logic        irq_n;

    modport master (
        output aen, size, wr_n, AD_in,
        input  AD_out, ad_oe, rdy_n, error_n, irq_n
    );

    modport slave (
        input  aen, size, wr_n, AD_in,
        output AD_out, ad_oe, rdy_n, error_n, irq_n
    );
endinterface

// File: rtl/fsb16_tgt_timer.sv
// fsb16_tgt_timer
//   Local-bus timeout timer. Down-counter loaded with TIMEOUT-1 when the
//   local request rises; expire is raised while the request is still
//   outstanding and the count has reached zero, i.e. TIMEOUT cycles after
//   the request rose.
//   clk    in  bus clock
//   rst    in  synchronous active-high reset
//   start  in  one-cycle pulse on the lb_req rising edge (reloads the count)
//   run    in  request outstanding
//   expire out terminal count reached while running
module fsb16_tgt_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = CW'(TIMEOUT - 1);
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/fsb16_target.sv
// fsb16_target
//   FSB16 responder: decodes the two-frame address phase, runs one local-bus
//   read or write per FSB transaction and returns rdy_n / error_n (plus read
//   data) to the initiator for exactly one cycle.
//   Optional feature macro: FSB16_TARGET_IRQ_EN (registered irq_n from
//   irq_src & irq_mask); when undefined irq_n is tied high.
// Ports
//   clk, rst                 bus clock, synchronous active-high reset
//   bus (fsb16_target_if.slave)  aen/size/wr_n/AD_in in; AD_out/ad_oe/
//                            rdy_n/error_n/irq_n out
//   lb_req/lb_we/lb_addr/lb_be/lb_wdata   local bus request side
//   lb_rdata/lb_ack/lb_err   local bus completion side
//   irq_src/irq_mask         level interrupt sources and enables
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for first address frame (addr[15:0], wr_n, size)
// ST_A1      | second address frame (addr[31:16]) and window decode
// ST_W_DATA  | write data frame; lb_req/lb_we raised on exit
// ST_R_TA    | read turnaround frame, AD bus not driven
// ST_LB_WAIT | local access outstanding, waiting for ack/err/timeout
// ST_RESP    | one-cycle rdy_n or error_n response
module fsb16_target
    import fsb16_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
    parameter int          TIMEOUT   = 16,
    parameter int          IRQ_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    fsb16_target_if.slave    bus,
    output logic             lb_req,
    output logic             lb_we,
    output logic [31:0]      lb_addr,
    output logic [1:0]       lb_be,
    output logic [15:0]      lb_wdata,
    input  logic [15:0]      lb_rdata,
    input  logic             lb_ack,
    input  logic             lb_err,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic [IRQ_W-1:0] irq_mask
);

    logic [2:0]  state_q, state_d;
    xfer_t       xfer_q, xfer_d;
    logic [15:0] wdata_q, wdata_d;
    logic        lb_req_q, lb_req_d;
    logic        lb_we_q, lb_we_d;
    logic        rdy_n_q, rdy_n_d;
    logic        error_n_q, error_n_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_out_q, ad_out_d;

    logic [31:0] addr_full;
    logic        tmr_expire;

    // Full address as seen during the second frame, before it is registered.
    assign addr_full = {bus.AD_in, xfer_q.addr[15:0]};

    always_comb begin
        state_d   = state_q;
        xfer_d    = xfer_q;
        wdata_d   = wdata_q;
        lb_req_d  = lb_req_q;
        lb_we_d   = lb_we_q;
        // Response outputs are single-cycle pulses: deasserted unless set below.
        rdy_n_d   = 1'b1;
        error_n_d = 1'b1;
        ad_oe_d   = 1'b0;
        ad_out_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.aen) begin
                    xfer_d.addr[15:0] = bus.AD_in;
                    xfer_d.is_wr      = bus.wr_n;
                    xfer_d.sz         = bus.size;
                    state_d           = ST_A1;
                end
            end
            ST_A1: begin
                if (!bus.aen) begin
                    // Truncated address phase: drop silently.
                    state_d = ST_IDLE;
                end else begin
                    xfer_d.addr[31:16] = bus.AD_in;
                    if ((addr_full & ADDR_MASK) != BASE_ADDR) begin
                        state_d   = ST_RESP;
                        error_n_d = 1'b0;
                    end else if (xfer_q.is_wr == FSB_WRITE) begin
                        state_d = ST_W_DATA;
                    end else begin
                        // Reads start the local access during the turnaround frame.
                        state_d  = ST_R_TA;
                        lb_req_d = 1'b1;
                        lb_we_d  = 1'b0;
                    end
                end
            end
            ST_W_DATA: begin
                wdata_d  = bus.AD_in;
                lb_req_d = 1'b1;
                lb_we_d  = 1'b1;
                state_d  = ST_LB_WAIT;
            end
            ST_R_TA: begin
                state_d = ST_LB_WAIT;
            end
            ST_LB_WAIT: begin
                // lb_err beats lb_ack; lb_ack beats a simultaneous timeout.
                if (lb_err || lb_ack || tmr_expire) begin
                    state_d  = ST_RESP;
                    lb_req_d = 1'b0;
                    lb_we_d  = 1'b0;
                    if (!lb_err && lb_ack) begin
                        rdy_n_d = 1'b0;
                        if (xfer_q.is_wr == FSB_READ) begin
                            ad_oe_d  = 1'b1;
                            ad_out_d = lb_rdata;
                        end
                    end else begin
                        error_n_d = 1'b0;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                lb_req_d = 1'b0;
                lb_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            xfer_q    <= '0;
            wdata_q   <= '0;
            lb_req_q  <= 1'b0;
            lb_we_q   <= 1'b0;
            rdy_n_q   <= 1'b1;
            error_n_q <= 1'b1;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            xfer_q    <= xfer_d;
            wdata_q   <= wdata_d;
            lb_req_q  <= lb_req_d;
            lb_we_q   <= lb_we_d;
            rdy_n_q   <= rdy_n_d;
            error_n_q <= error_n_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
        end
    end

    fsb16_tgt_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (lb_req_d & ~lb_req_q),
        .run    (lb_req_q),
        .expire (tmr_expire)
    );

    assign lb_req      = lb_req_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = xfer_q.addr;
    assign lb_be       = byte_en(xfer_q.sz, xfer_q.addr[0]);
    assign lb_wdata    = wdata_q;

    assign bus.AD_out  = ad_out_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.rdy_n   = rdy_n_q;
    assign bus.error_n = error_n_q;

`ifdef FSB16_TARGET_IRQ_EN
    logic irq_n_q, irq_n_d;

    always_comb begin
        irq_n_d = ~|(irq_src & irq_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_n_q <= 1'b1;
        end else begin
            irq_n_q <= irq_n_d;
        end
    end

    assign bus.irq_n = irq_n_q;
`else
    logic unused_irq;
    assign unused_irq = ^{irq_src, irq_mask};
    assign bus.irq_n  = 1'b1;
`endif

endmodule

// File: tb/tb_fsb16_target.sv
`timescale 1ns/1ps
module tb_fsb16_target;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MASK  = 32'hFFFF_0000;
    localparam int          TMO   = 16;
    localparam int          IRQ_W = 4;
`ifdef FSB16_TARGET_IRQ_EN
    localparam logic IRQ_ON = 1'b0;
`else
    localparam logic IRQ_ON = 1'b1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              lb_req, lb_we;
    logic [31:0]       lb_addr;
    logic [1:0]        lb_be;
    logic [15:0]       lb_wdata;
    logic [15:0]       lb_rdata;
    logic              lb_ack, lb_err;
    logic [IRQ_W-1:0]  irq_src, irq_mask;

    fsb16_target_if bus();

    fsb16_target #(
        .BASE_ADDR (BASE),
        .ADDR_MASK (MASK),
        .TIMEOUT   (TMO),
        .IRQ_W     (IRQ_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lb_req   (lb_req),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_be    (lb_be),
        .lb_wdata (lb_wdata),
        .lb_rdata (lb_rdata),
        .lb_ack   (lb_ack),
        .lb_err   (lb_err),
        .irq_src  (irq_src),
        .irq_mask (irq_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        err;
        logic        oe;
        logic        chk_data;
        logic [15:0] data;
    } rsp_t;

    typedef struct {
        int          cyc;
        logic        we;
        logic [31:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } lbx_t;

    rsp_t        rsp_q[$];
    lbx_t        lb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ack_dly = 0;
    logic        both_mode = 1'b0;
    logic [15:0] rd_val = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response scoreboard: every rdy_n/error_n pulse must match the oldest expectation.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.ad_oe) check("oe_only_with_rdy", 32'(bus.rdy_n), 32'h0);
                if (!bus.rdy_n || !bus.error_n) begin
                    if (rsp_q.size() == 0) begin
                        check("resp_unexpected", 32'({bus.rdy_n, bus.error_n}), 32'h3);
                    end else begin
                        e = rsp_q.pop_front();
                        check("resp_cyc", 32'(cyc), 32'(e.cyc));
                        check("rdy_n", 32'(bus.rdy_n), 32'(e.err));
                        check("error_n", 32'(bus.error_n), 32'(!e.err));
                        check("ad_oe", 32'(bus.ad_oe), 32'(e.oe));
                        if (e.chk_data) check("AD_out", 32'(bus.AD_out), 32'(e.data));
                        check("lb_req_drop", 32'(lb_req), 32'h0);
                    end
                end
            end
        end
    end

    // Local-bus responder and request checker.
    initial begin
        int   req_cnt;
        lbx_t x;
        req_cnt  = 0;
        lb_ack   = 1'b0;
        lb_err   = 1'b0;
        lb_rdata = 16'h0;
        forever begin
            @(negedge clk);
            lb_rdata = rd_val;
            if (lb_req && !rst) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    if (lb_q.size() == 0) begin
                        check("lb_unexpected", 32'(lb_req), 32'h0);
                    end else begin
                        x = lb_q.pop_front();
                        check("lb_req_cyc", 32'(cyc), 32'(x.cyc));
                        check("lb_we", 32'(lb_we), 32'(x.we));
                        check("lb_addr", lb_addr, x.addr);
                        check("lb_be", 32'(lb_be), 32'(x.be));
                        if (x.we) check("lb_wdata", 32'(lb_wdata), 32'(x.wdata));
                    end
                end
                if (ack_dly > 0 && req_cnt >= ack_dly) begin
                    lb_ack = 1'b1;
                    lb_err = both_mode;
                end
            end else begin
                req_cnt = 0;
                lb_ack  = 1'b0;
                lb_err  = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic idle_bus();
        bus.aen   = 1'b0;
        bus.size  = 1'b0;
        bus.wr_n  = 1'b0;
        bus.AD_in = 16'h0;
    endtask

    // Called right after a negedge: drives the two address frames and the data/nop frame.
    task automatic drive_frames(input logic wr, input logic sz, input logic [31:0] addr,
                                input logic [15:0] wdata);
        bus.aen   = 1'b1;
        bus.wr_n  = wr;
        bus.size  = sz;
        bus.AD_in = addr[15:0];
        @(negedge clk);
        bus.AD_in = addr[31:16];
        @(negedge clk);
        bus.aen   = 1'b0;
        bus.AD_in = wr ? wdata : 16'h0;
        @(negedge clk);
        bus.AD_in = 16'h0;
    endtask

    // dly: cycles from lb_req rise to lb_ack (0 = never); both: lb_err with lb_ack.
    task automatic run_txn(input logic wr, input logic sz, input logic [31:0] addr,
                           input logic [15:0] wdata, input logic [15:0] rdata,
                           input int dly, input logic both, input logic poke);
        rsp_t r;
        lbx_t x;
        int   t0, req_edge, e_edge, n;
        logic hit;
        @(negedge clk);
        t0        = cyc;
        hit       = ((addr & MASK) == BASE);
        ack_dly   = dly;
        both_mode = both;
        rd_val    = rdata;
        if (!hit) begin
            r.cyc = t0 + 2; r.err = 1'b1; r.oe = 1'b0; r.chk_data = 1'b1; r.data = 16'h0;
        end else begin
            req_edge = wr ? 2 : 1;
            x.cyc   = t0 + 1 + req_edge;
            x.we    = wr;
            x.addr  = addr;
            x.be    = sz ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
            x.wdata = wdata;
            lb_q.push_back(x);
            if (dly >= 1 && dly <= TMO) begin
                e_edge = (req_edge + dly > 3) ? req_edge + dly : 3;
                r.err  = both;
            end else begin
                e_edge = req_edge + TMO;
                r.err  = 1'b1;
            end
            r.cyc      = t0 + 1 + e_edge;
            r.oe       = !r.err && !wr;
            r.chk_data = r.err || !wr;
            r.data     = r.err ? 16'h0 : rdata;
        end
        rsp_q.push_back(r);
        drive_frames(wr, sz, addr, wdata);
        n = 0;
        while ((rsp_q.size() != 0 || lb_q.size() != 0) && n < 60) begin
            if (poke && n == 3) begin
                bus.aen = 1'b1; bus.wr_n = 1'b1; bus.AD_in = 16'hFFFF;
            end else begin
                bus.aen = 1'b0; bus.AD_in = 16'h0;
            end
            @(negedge clk);
            #1;
            n++;
        end
        bus.aen = 1'b0;
        if (n >= 60) begin
            check("txn_done", 32'h0, 32'h1);
            rsp_q.delete();
            lb_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rdy_n"},   32'(bus.rdy_n),   32'h1);
        check({pfx, "_error_n"}, 32'(bus.error_n), 32'h1);
        check({pfx, "_irq_n"},   32'(bus.irq_n),   32'h1);
        check({pfx, "_ad_oe"},   32'(bus.ad_oe),   32'h0);
        check({pfx, "_AD_out"},  32'(bus.AD_out),  32'h0);
        check({pfx, "_lb_req"},  32'(lb_req),      32'h0);
        check({pfx, "_lb_we"},   32'(lb_we),       32'h0);
    endtask

    initial begin
        lbx_t x;
        idle_bus();
        irq_src  = '0;
        irq_mask = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        run_txn(1'b1, 1'b1, 32'h0000_0010, 16'hBEEF, 16'h0,    2,   1'b0, 1'b0);
        run_txn(1'b0, 1'b0, 32'h0000_0022, 16'h0,    16'h1234, 1,   1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0001_0000, 16'h0,    16'hDEAD, 2,   1'b0, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0040, 16'h0,    16'h5555, 0,   1'b0, 1'b1);
        run_txn(1'b0, 1'b1, 32'h0000_0044, 16'h0,    16'h7777, 3,   1'b1, 1'b0);
        run_txn(1'b0, 1'b1, 32'h0000_0048, 16'h0,    16'hCAFE, TMO, 1'b0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0000_0033, 16'h00AB, 16'h0,    1,   1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h0000_0060, 16'h1111, 16'h0,    0,   1'b0, 1'b0);
        run_txn(1'b1, 1'b1, 32'hFFFF_0010, 16'h2222, 16'h0,    1,   1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 16'hFFFF)), 16'($urandom), 16'($urandom),
                    int'($urandom_range(1, 5)), 1'b0, 1'b0);
        end

        // Address phase cut short after the first frame: no access, no response.
        @(negedge clk);
        bus.aen = 1'b1; bus.wr_n = 1'b1; bus.size = 1'b1; bus.AD_in = 16'h0050;
        @(negedge clk);
        bus.aen = 1'b0; bus.AD_in = 16'h0;
        repeat (6) @(negedge clk);
        check("proto_no_req", 32'(lb_req), 32'h0);
        check("proto_no_resp", 32'({bus.rdy_n, bus.error_n}), 32'h3);
        run_txn(1'b0, 1'b1, 32'h0000_0070, 16'h0, 16'h9876, 2, 1'b0, 1'b0);

        // Reset while the local access is outstanding.
        @(negedge clk);
        ack_dly   = 0;
        both_mode = 1'b0;
        x.cyc = cyc + 3; x.we = 1'b1; x.addr = 32'h0000_0200; x.be = 2'b11; x.wdata = 16'hA5A5;
        lb_q.push_back(x);
        drive_frames(1'b1, 1'b1, 32'h0000_0200, 16'hA5A5);
        repeat (3) @(negedge clk);
        check("pre_rst_lb_req", 32'(lb_req), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        repeat (24) @(negedge clk);
        run_txn(1'b0, 1'b1, 32'h0000_0080, 16'h0, 16'h4321, 1, 1'b0, 1'b0);

        // Interrupt output.
        @(negedge clk);
        irq_src  = 4'b0100;
        irq_mask = 4'b0100;
        #1;
        check("irq_n_registered", 32'(bus.irq_n), 32'h1);
        @(negedge clk);
        check("irq_n_on", 32'(bus.irq_n), 32'(IRQ_ON));
        irq_mask = 4'b0000;
        @(negedge clk);
        check("irq_n_masked", 32'(bus.irq_n), 32'h1);
        irq_src  = 4'b1011;
        irq_mask = 4'b0010;
        @(negedge clk);
        check("irq_n_on2", 32'(bus.irq_n), 32'(IRQ_ON));
        irq_src  = 4'b0001;
        @(negedge clk);
        check("irq_n_off2", 32'(bus.irq_n), 32'h1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
